// File: rtl/fft_pkg.sv
// Shared fixed-point defaults and complex sample type for the FFT datapath.
// Q-format is signed INT.FRACT two's complement.
package fft_pkg;

    localparam int FFT_INT_WIDTH   = 8;
    localparam int FFT_FRACT_WIDTH = 8;
    localparam int FFT_DATA_WIDTH  = FFT_INT_WIDTH + FFT_FRACT_WIDTH;

    localparam logic [FFT_DATA_WIDTH-1:0] FFT_ONE =
        FFT_DATA_WIDTH'(1) << FFT_FRACT_WIDTH;

    typedef struct packed {
        logic [FFT_DATA_WIDTH-1:0] re;
        logic [FFT_DATA_WIDTH-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_multiply.sv
// Signed Q-format multiply: full-width product, keep the middle DATA bits.
// Dropping the low FRACT bits truncates toward -inf.
module fft_multiply
    import fft_pkg::*;
#(
    parameter int INT_WIDTH   = FFT_INT_WIDTH,
    parameter int FRACT_WIDTH = FFT_FRACT_WIDTH
) (
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0] a,
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0] b,
    output logic [INT_WIDTH+FRACT_WIDTH-1:0] p
);

    localparam int DW = INT_WIDTH + FRACT_WIDTH;

    logic [2*DW-1:0]        full;
    logic [INT_WIDTH-1:0]   hi_unused;
    logic [FRACT_WIDTH-1:0] lo_unused;

    // Sign-extended operands: low 2*DW bits equal the signed product.
    assign full = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
    assign {hi_unused, p, lo_unused} = full;

endmodule

// File: rtl/ifft_dif_butterfly_pipe.sv
// Three-stage radix-2 DIF butterfly for the inverse path, using conj(w).
// Valid/ready on both sides with per-stage stall and bubble collapsing.
module ifft_dif_butterfly_pipe
    import fft_pkg::*;
#(
    parameter int INT_WIDTH   = FFT_INT_WIDTH,
    parameter int FRACT_WIDTH = FFT_FRACT_WIDTH,
    parameter int DATA_WIDTH  = INT_WIDTH + FRACT_WIDTH,
    parameter bit SCALE       = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a_real,
    input  logic [DATA_WIDTH-1:0] a_imag,
    input  logic [DATA_WIDTH-1:0] b_real,
    input  logic [DATA_WIDTH-1:0] b_imag,
    input  logic [DATA_WIDTH-1:0] w_r,
    input  logic [DATA_WIDTH-1:0] w_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out0_real,
    output logic [DATA_WIDTH-1:0] out0_imag,
    output logic [DATA_WIDTH-1:0] out1_real,
    output logic [DATA_WIDTH-1:0] out1_imag
);

    localparam int DW = DATA_WIDTH;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cpx_t;

    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic v3_q, v3_d;

    cpx_t sum1_q, sum1_d;
    cpx_t dif1_q, dif1_d;
    cpx_t tw1_q,  tw1_d;
    cpx_t sum2_q, sum2_d;
    cpx_t rot2_q, rot2_d;
    cpx_t out0_q, out0_d;
    cpx_t out1_q, out1_d;

    logic en1, en2, en3;
    logic [DW-1:0] p0, p1, p2, p3;

    function automatic logic [DW-1:0] scale_fn(input logic [DW-1:0] x);
        return SCALE ? {x[DW-1], x[DW-1:1]} : x;
    endfunction

    fft_multiply #(
        .INT_WIDTH  (INT_WIDTH),
        .FRACT_WIDTH(FRACT_WIDTH)
    ) u_mul_p0 (
        .a(dif1_q.re),
        .b(tw1_q.re),
        .p(p0)
    );

    fft_multiply #(
        .INT_WIDTH  (INT_WIDTH),
        .FRACT_WIDTH(FRACT_WIDTH)
    ) u_mul_p1 (
        .a(dif1_q.im),
        .b(tw1_q.im),
        .p(p1)
    );

    fft_multiply #(
        .INT_WIDTH  (INT_WIDTH),
        .FRACT_WIDTH(FRACT_WIDTH)
    ) u_mul_p2 (
        .a(dif1_q.im),
        .b(tw1_q.re),
        .p(p2)
    );

    fft_multiply #(
        .INT_WIDTH  (INT_WIDTH),
        .FRACT_WIDTH(FRACT_WIDTH)
    ) u_mul_p3 (
        .a(dif1_q.re),
        .b(tw1_q.im),
        .p(p3)
    );

    // An empty stage may always load, so bubbles collapse under stall.
    always_comb begin
        en3 = out_ready || !v3_q;
        en2 = en3 || !v2_q;
        en1 = en2 || !v1_q;
    end

    always_comb begin
        v1_d   = v1_q;
        sum1_d = sum1_q;
        dif1_d = dif1_q;
        tw1_d  = tw1_q;
        v2_d   = v2_q;
        sum2_d = sum2_q;
        rot2_d = rot2_q;
        v3_d   = v3_q;
        out0_d = out0_q;
        out1_d = out1_q;

        if (en1) begin
            v1_d      = in_valid;
            sum1_d.re = a_real + b_real;
            sum1_d.im = a_imag + b_imag;
            dif1_d.re = a_real - b_real;
            dif1_d.im = a_imag - b_imag;
            tw1_d.re  = w_r;
            tw1_d.im  = w_i;
        end

        // d * conj(w) = (dr*wr + di*wi) + j(di*wr - dr*wi)
        if (en2) begin
            v2_d      = v1_q;
            sum2_d    = sum1_q;
            rot2_d.re = p0 + p1;
            rot2_d.im = p2 - p3;
        end

        if (en3) begin
            v3_d      = v2_q;
            out0_d.re = scale_fn(sum2_q.re);
            out0_d.im = scale_fn(sum2_q.im);
            out1_d.re = scale_fn(rot2_q.re);
            out1_d.im = scale_fn(rot2_q.im);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            sum1_q <= '0;
            dif1_q <= '0;
            tw1_q  <= '0;
            sum2_q <= '0;
            rot2_q <= '0;
            out0_q <= '0;
            out1_q <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
            sum1_q <= sum1_d;
            dif1_q <= dif1_d;
            tw1_q  <= tw1_d;
            sum2_q <= sum2_d;
            rot2_q <= rot2_d;
            out0_q <= out0_d;
            out1_q <= out1_d;
        end
    end

    assign in_ready  = en1;
    assign out_valid = v3_q;
    assign out0_real = out0_q.re;
    assign out0_imag = out0_q.im;
    assign out1_real = out1_q.re;
    assign out1_imag = out1_q.im;

endmodule

// File: tb/tb_ifft_dif_butterfly_pipe.sv
// Bench for ifft_dif_butterfly_pipe: unscaled and scaled instances side by side,
// directed vector table, random scoreboard runs, backpressure and reset cases.
module tb_ifft_dif_butterfly_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [15:0] ar, ai, br, bi, wr, wi;

    logic        rdy0, ov0, rdy1, ov1;
    logic [15:0] x0r, x0i, x1r, x1i;
    logic [15:0] y0r, y0i, y1r, y1i;
    logic [63:0] res0, res1;

    int total = 0;
    int bad   = 0;
    int nin   = 0;
    int nout  = 0;
    int run   = 0;
    int maxrun = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];

    typedef struct {
        logic [15:0] ar, ai, br, bi, wr, wi;
        logic [63:0] e0, e1;
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    assign res0 = {x0r, x0i, x1r, x1i};
    assign res1 = {y0r, y0i, y1r, y1i};

    ifft_dif_butterfly_pipe #(.SCALE(1'b0)) dut0 (
        .CLK(clk), .RST(rst_n),
        .in_valid(in_valid), .in_ready(rdy0),
        .a_real(ar), .a_imag(ai), .b_real(br), .b_imag(bi),
        .w_r(wr), .w_i(wi),
        .out_valid(ov0), .out_ready(out_ready),
        .out0_real(x0r), .out0_imag(x0i),
        .out1_real(x1r), .out1_imag(x1i)
    );

    ifft_dif_butterfly_pipe #(.SCALE(1'b1)) dut1 (
        .CLK(clk), .RST(rst_n),
        .in_valid(in_valid), .in_ready(rdy1),
        .a_real(ar), .a_imag(ai), .b_real(br), .b_imag(bi),
        .w_r(wr), .w_i(wi),
        .out_valid(ov1), .out_ready(out_ready),
        .out0_real(y0r), .out0_imag(y0i),
        .out1_real(y1r), .out1_imag(y1i)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Reference: complex arithmetic on signed integers, wrap to 16 bits.
    function automatic longint sx(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint wrap16(input longint x);
        logic [15:0] t;
        t = x[15:0];
        return sx(t);
    endfunction

    function automatic longint qmul(input longint x, input longint y);
        return wrap16((x * y) >>> 8);
    endfunction

    function automatic logic [63:0] model(
        input logic [15:0] a_r, a_i, b_r, b_i, w_r, w_i,
        input bit sc);
        longint v[4];
        longint dr, di;
        logic [63:0] r;
        v[0] = wrap16(sx(a_r) + sx(b_r));
        v[1] = wrap16(sx(a_i) + sx(b_i));
        dr   = wrap16(sx(a_r) - sx(b_r));
        di   = wrap16(sx(a_i) - sx(b_i));
        v[2] = wrap16(qmul(dr, sx(w_r)) + qmul(di, sx(w_i)));
        v[3] = wrap16(qmul(di, sx(w_r)) - qmul(dr, sx(w_i)));
        for (int k = 0; k < 4; k++) begin
            if (sc) v[k] = v[k] >>> 1;
            r[63-16*k -: 16] = 16'(v[k]);
        end
        return r;
    endfunction

    function automatic vec_t mk(
        input logic [15:0] a_r, a_i, b_r, b_i, w_r, w_i,
        input logic [63:0] e0, e1);
        vec_t t;
        t.ar = a_r; t.ai = a_i; t.br = b_r;
        t.bi = b_i; t.wr = w_r; t.wi = w_i;
        t.e0 = e0;  t.e1 = e1;
        return t;
    endfunction

    task automatic set_in(input logic [15:0] a_r, a_i, b_r, b_i, w_r, w_i);
        ar = a_r; ai = a_i; br = b_r; bi = b_i; wr = w_r; wi = w_i;
    endtask

    task automatic set_rand();
        set_in(16'($urandom), 16'($urandom), 16'($urandom),
               16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    // One cycle: inspect handshakes mid-cycle, then advance past the edge.
    task automatic step();
        @(negedge clk);
        chk("rdy_match", {63'd0, rdy1}, {63'd0, rdy0});
        chk("ov_match", {63'd0, ov1}, {63'd0, ov0});
        if (ov0 && out_ready) begin
            nout++;
            run++;
            if (run > maxrun) maxrun = run;
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out act=%h exp=none", res0);
            end else begin
                chk("sb_s0", res0, q0.pop_front());
                chk("sb_s1", res1, q1.pop_front());
            end
        end else begin
            run = 0;
        end
        if (in_valid && rdy0) begin
            nin++;
            q0.push_back(model(ar, ai, br, bi, wr, wi, 1'b0));
            q1.push_back(model(ar, ai, br, bi, wr, wi, 1'b1));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n0;
        int idx;
        bit have_snap;
        logic [63:0] snap;
        logic [15:0] it[5][6];

        tbl[0] = mk(16'h0200, 0, 16'h0100, 0, 16'h0100, 0,
                    {16'h0300, 16'h0, 16'h0100, 16'h0},
                    {16'h0180, 16'h0, 16'h0080, 16'h0});
        tbl[1] = mk(16'h0100, 0, 0, 0, 16'h0000, 16'hFF00,
                    {16'h0100, 16'h0, 16'h0000, 16'h0100},
                    {16'h0080, 16'h0, 16'h0000, 16'h0080});
        tbl[2] = mk(16'h0300, 0, 0, 0, 16'h0100, 0,
                    {16'h0300, 16'h0, 16'h0300, 16'h0},
                    {16'h0180, 16'h0, 16'h0180, 16'h0});
        tbl[3] = mk(16'hFFFF, 0, 0, 0, 16'h0100, 0,
                    {16'hFFFF, 16'h0, 16'hFFFF, 16'h0},
                    {16'hFFFF, 16'h0, 16'hFFFF, 16'h0});
        tbl[4] = mk(16'h7F00, 0, 16'h0100, 0, 16'h0100, 0,
                    {16'h8000, 16'h0, 16'h7E00, 16'h0},
                    {16'hC000, 16'h0, 16'h3F00, 16'h0});
        tbl[5] = mk(16'h0100, 16'h0200, 16'h0080, 16'h0100,
                    16'h0080, 16'h0080,
                    {16'h0180, 16'h0300, 16'h00C0, 16'h0040},
                    {16'h00C0, 16'h0180, 16'h0060, 16'h0020});
        tbl[6] = mk(0, 0, 16'h0001, 0, 16'h0080, 0,
                    {16'h0001, 16'h0, 16'hFFFF, 16'h0},
                    {16'h0000, 16'h0, 16'hFFFF, 16'h0});

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_ov", {62'd0, ov1, ov0}, 64'd0);
        chk("rst_out0", res0, 64'd0);
        chk("rst_out1", res1, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy", {62'd0, rdy1, rdy0}, 64'd3);
        @(posedge clk);
        #1;

        // Directed table: latency and exact values for both scalings.
        for (int v = 0; v < 7; v++) begin
            set_in(tbl[v].ar, tbl[v].ai, tbl[v].br,
                   tbl[v].bi, tbl[v].wr, tbl[v].wi);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 1;
            while (!ov0 && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk($sformatf("lat_%0d", v), 64'(lat), 64'd3);
            chk($sformatf("vec_s0_%0d", v), res0, tbl[v].e0);
            chk($sformatf("vec_s1_%0d", v), res1, tbl[v].e1);
            @(posedge clk);
            #1;
        end

        // Back-to-back stream including the wrap vector.
        nout = 0;
        maxrun = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) set_in(16'h7F00, 0, 16'h0100, 0, 16'h0100, 0);
            else set_rand();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (5) step();
        chk("stream_cnt", 64'(nout), 64'd16);
        chk("stream_run", 64'(maxrun >= 16), 64'd1);
        chk("stream_empty", 64'(q0.size()), 64'd0);

        // Random valid/ready traffic.
        for (int i = 0; i < 300; i++) begin
            set_rand();
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        chk("rand_empty", 64'(q0.size() + q1.size()), 64'd0);

        // Backpressure: five items against a stalled sink.
        for (int k = 0; k < 5; k++)
            for (int j = 0; j < 6; j++)
                it[k][j] = 16'($urandom);
        out_ready = 1'b0;
        n0 = nin;
        nout = 0;
        idx = 0;
        have_snap = 1'b0;
        snap = '0;
        for (int c = 0; c < 8; c++) begin
            set_in(it[idx][0], it[idx][1], it[idx][2],
                   it[idx][3], it[idx][4], it[idx][5]);
            in_valid = 1'b1;
            lat = nin;
            step();
            if (nin != lat) idx++;
            if (ov0) begin
                if (have_snap) chk("hold_data", res0, snap);
                else snap = res0;
                have_snap = 1'b1;
            end
        end
        chk("bp_accepted", 64'(nin - n0), 64'd3);
        chk("bp_in_ready", {63'd0, rdy0}, 64'd0);
        chk("bp_ov_held", {62'd0, ov1, ov0}, 64'd3);
        chk("bp_no_out", 64'(nout), 64'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 5; c++) begin
            set_in(it[idx][0], it[idx][1], it[idx][2],
                   it[idx][3], it[idx][4], it[idx][5]);
            lat = nin;
            step();
            if (nin != lat) idx++;
        end
        in_valid = 1'b0;
        repeat (6) step();
        chk("bp_in_cnt", 64'(nin - n0), 64'd5);
        chk("bp_out_cnt", 64'(nout), 64'd5);
        chk("bp_empty", 64'(q0.size()), 64'd0);

        // Reset with two items in flight.
        out_ready = 1'b0;
        set_in(16'h0400, 16'h0200, 0, 0, 16'h0100, 0);
        in_valid = 1'b1;
        step();
        set_in(16'h0600, 0, 16'h0100, 0, 16'h0100, 0);
        step();
        in_valid = 1'b0;
        step();
        chk("pre_rst_ov", {62'd0, ov1, ov0}, 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", {62'd0, ov1, ov0}, 64'd0);
        chk("mid_rst_out0", res0, 64'd0);
        chk("mid_rst_out1", res1, 64'd0);
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_rdy", {62'd0, rdy1, rdy0}, 64'd3);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        nout = 0;
        repeat (6) step();
        chk("post_rst_quiet", 64'(nout), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifft_dif_butterfly_pipe.md
Name: ifft_dif_butterfly_pipe

Overview:
- Pipelined radix-2 decimation-in-frequency (DIF) butterfly for the inverse transform path.
- It is the inverse counterpart of the existing combinational DIT forward butterfly.
- Accepts one complex pair plus a forward-convention twiddle per transfer and conjugates the twiddle internally.
- Optionally scales results by 1/2 per stage, so three chained instances give the 1/8 IFFT normalisation.
- Valid/ready handshake on both sides; 3-stage pipeline with per-stage stall.

Parameters:
- INT_WIDTH, 8, integer field width (signed two's-complement fixed point).
- FRACT_WIDTH, 8, fractional field width.
- DATA_WIDTH, INT_WIDTH+FRACT_WIDTH, total sample width.
- SCALE, 1, 1 = arithmetic shift right by 1 on both outputs; 0 = no scaling.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- in_valid  in  1  input pair and twiddle valid.
- in_ready  out  1  pipeline can accept this cycle.
- a_real, a_imag  in  DATA_WIDTH  upper input.
- b_real, b_imag  in  DATA_WIDTH  lower input.
- w_r, w_i  in  DATA_WIDTH  forward twiddle; the block uses conj(w).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out0_real, out0_imag  out  DATA_WIDTH  (a+b)·s.
- out1_real, out1_imag  out  DATA_WIDTH  ((a−b)·conj(w))·s.

Behaviour:
- Interface (already decided): one clock, CLK; reset RST is asynchronous and active-low. All state registers reset while RST=0 regardless of clock.
- Reset values: out_valid=0; all output data=0; all internal stage valids v1..v3=0. in_ready reflects the empty pipeline (1) once RST deasserts.
- Transfers: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Stage 1 (register): sr=a+b, si=a+b (imag), dr=a−b, di=a−b (imag). Twiddle is captured alongside.
- Stage 2 (register): products via four multiply instances:
  - p0=dr·wr, p1=di·wi, p2=di·wr, p3=dr·wi.
  - out1 = (p0+p1) + j(p2−p3), i.e. d times conj(w).
  - Sum terms are delayed one stage alongside.
- Stage 3 (register): optional scaling (>>>1, arithmetic, truncation toward −inf), then drive outputs. out_valid=v3.
- Multiply rule: full 2·DATA_WIDTH signed product; result = bits [FRACT_WIDTH +: DATA_WIDTH]. This truncates toward −inf.
- Overflow: all add/sub wrap modulo 2^DATA_WIDTH. No saturation.
- Latency: exactly 3 cycles from input transfer to out_valid when out_ready=1. Throughput is 1 transfer per cycle.
- Stall logic:
  - en3 = out_ready || !v3
  - en2 = en3 || !v2
  - en1 = en2 || !v1
  - in_ready = en1, which is combinational from out_ready.
- Stage register rule: a stage whose enable is 0 holds data and valid. A stage whose enable is 1 loads from the previous stage, including bubbles (valid=0).
- Bubble collapsing: an empty stage accepts data even while downstream stalls.
- Backpressure: when out_ready=0, the pipeline absorbs at most 3 transfers. After that in_ready=0 and no data is lost or duplicated.
- Output stability: while out_valid=1 and out_ready=0, outputs hold stable.
- Data gating: data registers load only on their enable; valid-0 data is don't-care internally.
- Reset mid-operation: all in-flight results are discarded. out_valid drops asynchronously with RST low.
- Simultaneous in/out transfer when full: allowed, and keeps throughput at 1/cycle.

Decomposition:
- Package fft_pkg holds:
  - INT_WIDTH/FRACT_WIDTH defaults.
  - The Q-format ONE constant (1<<FRACT_WIDTH).
  - A typedef for a complex sample (real, imag pair).
- Sub-module: reuse the existing multiply module (four instances), parameterised with INT_WIDTH/FRACT_WIDTH. There is no new sub-module.

Test Plan:
- Basic, SCALE=0: a=(0x0200,0), b=(0x0100,0), w=(0x0100,0) -> after 3 cycles out0=(0x0300,0), out1=(0x0100,0).
- Conjugate twiddle, SCALE=0: a=(0x0100,0), b=0, w=(0x0000,0xFF00) [−j] -> out0=(0x0100,0), out1=(0x0000,0x0100) [+j].
- Scaling, SCALE=1:
  - a=(0x0300,0), b=0, w=(0x0100,0) -> out0=out1=(0x0180,0).
  - a=(0xFFFF,0), b=0 -> out0 real=0xFFFF (floor).
- Backpressure: hold out_ready=0 and stream 5 inputs with in_valid=1. Require in_ready=0 after 3 accepted transfers. Then out_ready=1 -> 5 outputs in order, no loss or duplication, out_valid held with stable data while stalled.
- Full throughput and wrap: 16 back-to-back inputs with out_ready=1 -> 16 consecutive output cycles.
  - Include a=(0x7F00,0), b=(0x0100,0), SCALE=0 -> out0 real=0x8000 (wrap).
- Reset mid-stream: assert RST=0 asynchronously with 2 items in flight -> out_valid=0 and outputs=0 immediately. After release: in_ready=1 and no stale output appears.
